decode_issue: RTL and testbench

- Decode/issue stage that feeds the execution ALU.
- Accepts one 32-bit MIPS instruction per cycle over a valid/ready handshake and reads rs/rt from the register file combinationally.
- Produces registered operands d1/d2, the 5-bit aluctrl code and writeback info toward the execution stage over a second valid/ready handshake.
- A 2-entry skid buffer decouples upstream and downstream stalls.

---
 rtl/decode_issue.sv | 199 +++++++++++++++++++
 tb/tb_decode_issue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// Decode/issue stage: MIPS word plus register-file operands in, ALU operands and writeback info out.
// Latency: 1 cycle from accept to ex_valid.
// Backpressure: 2-entry skid with registered instr_ready (SKID_EN=1), else a single pass-through register.
module decode_issue #(
  parameter bit SKID_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_d1,
  output logic [31:0] ex_d2,
  output logic [4:0]  ex_aluctrl,
  output logic [4:0]  ex_wr_reg,
  output logic        ex_wr_en,
  output logic        ex_illegal
);

  localparam logic [4:0] ALU_ADD  = 5'b00010;
  localparam logic [4:0] ALU_SUB  = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_OR   = 5'b00001;
  localparam logic [4:0] ALU_NOR  = 5'b01100;
  localparam logic [4:0] ALU_PASS = 5'b00111;
  localparam logic [4:0] ALU_SLL  = 5'b01101;
  localparam logic [4:0] ALU_SRL  = 5'b01110;
  localparam logic [4:0] ALU_SRA  = 5'b01111;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  aluctrl;
    logic [4:0]  wr_reg;
    logic        wr_en;
    logic        illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;

  assign op      = instr[31:26];
  assign rs_addr = instr[25:21];
  assign rt_addr = instr[20:16];
  assign rd      = instr[15:11];
  assign shamt   = instr[10:6];
  assign funct   = instr[5:0];
  assign imm     = instr[15:0];

  entry_t      dec;
  logic        legal;
  logic [4:0]  dest;
  logic [4:0]  alu;
  logic [31:0] d1;
  logic [31:0] d2;

  always_comb begin
    legal = 1'b1;
    dest  = rd;
    alu   = ALU_PASS;
    d1    = rs_data;
    d2    = rt_data;
    if (op == 6'h00) begin
      case (funct)
        6'h20, 6'h21: alu = ALU_ADD;
        6'h22, 6'h23: alu = ALU_SUB;
        6'h24:        alu = ALU_AND;
        6'h25:        alu = ALU_OR;
        6'h27:        alu = ALU_NOR;
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
          // Shifts put the shifted value in d1 and the amount in d2
          d1 = rt_data;
          d2 = funct[2] ? {27'b0, rs_data[4:0]} : {27'b0, shamt};
          case (funct[1:0])
            2'b00:   alu = ALU_SLL;
            2'b10:   alu = ALU_SRL;
            default: alu = ALU_SRA;
          endcase
        end
        default: legal = 1'b0;
      endcase
    end else begin
      dest = rt_addr;
      case (op)
        6'h08, 6'h09: begin alu = ALU_ADD; d2 = {{16{imm[15]}}, imm}; end
        6'h0C:        begin alu = ALU_AND; d2 = {16'b0, imm}; end
        6'h0D:        begin alu = ALU_OR;  d2 = {16'b0, imm}; end
        6'h0F:        begin alu = ALU_PASS; d1 = 32'b0; d2 = {imm, 16'b0}; end
        default:      legal = 1'b0;
      endcase
    end

    if (legal) begin
      dec.d1      = d1;
      dec.d2      = d2;
      dec.aluctrl = alu;
      dec.wr_reg  = dest;
      dec.wr_en   = (dest != 5'd0);
      dec.illegal = 1'b0;
    end else begin
      dec.d1      = 32'b0;
      dec.d2      = 32'b0;
      dec.aluctrl = ALU_PASS;
      dec.wr_reg  = 5'd0;
      dec.wr_en   = 1'b0;
      dec.illegal = 1'b1;
    end
  end

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   ready_q, ready_d;
  logic   accept;
  logic   pop;

  assign ex_valid    = (state_q != EMPTY);
  assign instr_ready = SKID_EN ? ready_q : (!ex_valid || ex_ready);
  assign accept      = instr_valid && instr_ready;
  assign pop         = ex_valid && ex_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = dec;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_d = dec;
        end else if (accept && SKID_EN) begin
          state_d = FULL;
          skid_d  = dec;
        end else if (pop) begin
          state_d = EMPTY;
          main_d  = '0;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = '0;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end
    endcase
    // Flush wins over a same-cycle accept; the incoming word is dropped
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign ex_d1      = main_q.d1;
  assign ex_d2      = main_q.d2;
  assign ex_aluctrl = main_q.aluctrl;
  assign ex_wr_reg  = main_q.wr_reg;
  assign ex_wr_en   = main_q.wr_en;
  assign ex_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed steps then random traffic against a queue-based reference model.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst, flush, instr_valid, instr_ready, ex_valid, ex_ready;
  logic [31:0] instr, rs_data, rt_data, ex_d1, ex_d2;
  logic [4:0]  rs_addr, rt_addr, ex_aluctrl, ex_wr_reg;
  logic        ex_wr_en, ex_illegal;

  always #5 clk = ~clk;

  decode_issue #(.SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_d1(ex_d1), .ex_d2(ex_d2), .ex_aluctrl(ex_aluctrl),
    .ex_wr_reg(ex_wr_reg), .ex_wr_en(ex_wr_en), .ex_illegal(ex_illegal)
  );

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  alu;
    logic [4:0]  wr;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   cleared;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode, written straight from the instruction table
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [5:0]  op, fn;
    logic [15:0] imm;
    bit          ok;
    op  = ins[31:26];
    fn  = ins[5:0];
    imm = ins[15:0];
    ok  = 1'b1;
    e.d1 = a; e.d2 = b; e.alu = 5'b00111;
    if (op == 0) begin
      e.wr = ins[15:11];
      if (fn == 6'h20 || fn == 6'h21)      e.alu = 5'b00010;
      else if (fn == 6'h22 || fn == 6'h23) e.alu = 5'b00110;
      else if (fn == 6'h24)                e.alu = 5'b00000;
      else if (fn == 6'h25)                e.alu = 5'b00001;
      else if (fn == 6'h27)                e.alu = 5'b01100;
      else if (fn == 6'h00 || fn == 6'h04) begin e.alu = 5'b01101; e.d1 = b; e.d2 = (fn == 6'h00) ? 32'(ins[10:6]) : a % 32; end
      else if (fn == 6'h02 || fn == 6'h06) begin e.alu = 5'b01110; e.d1 = b; e.d2 = (fn == 6'h02) ? 32'(ins[10:6]) : a % 32; end
      else if (fn == 6'h03 || fn == 6'h07) begin e.alu = 5'b01111; e.d1 = b; e.d2 = (fn == 6'h03) ? 32'(ins[10:6]) : a % 32; end
      else ok = 1'b0;
    end else begin
      e.wr = ins[20:16];
      if (op == 6'h08 || op == 6'h09) begin e.alu = 5'b00010; e.d2 = (imm >= 16'h8000) ? 32'(imm) + 32'hFFFF0000 : 32'(imm); end
      else if (op == 6'h0C)           begin e.alu = 5'b00000; e.d2 = 32'(imm); end
      else if (op == 6'h0D)           begin e.alu = 5'b00001; e.d2 = 32'(imm); end
      else if (op == 6'h0F)           begin e.alu = 5'b00111; e.d1 = 0; e.d2 = 32'(imm) * 65536; end
      else ok = 1'b0;
    end
    e.we  = ok && (e.wr != 0);
    e.ill = !ok;
    if (!ok) begin e.d1 = 0; e.d2 = 0; e.alu = 5'b00111; e.wr = 0; end
    return e;
  endfunction

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic check_outputs();
    chk("instr_ready", 32'(instr_ready), 32'(q.size() < 2));
    chk("ex_valid", 32'(ex_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("ex_d1", ex_d1, q[0].d1);
      chk("ex_d2", ex_d2, q[0].d2);
      chk("ex_aluctrl", 32'(ex_aluctrl), 32'(q[0].alu));
      chk("ex_wr_reg", 32'(ex_wr_reg), 32'(q[0].wr));
      chk("ex_wr_en", 32'(ex_wr_en), 32'(q[0].we));
      chk("ex_illegal", 32'(ex_illegal), 32'(q[0].ill));
    end else if (cleared) begin
      chk("clr_d1", ex_d1, 32'd0);
      chk("clr_d2", ex_d2, 32'd0);
      chk("clr_misc", {19'd0, ex_aluctrl, ex_wr_reg, ex_wr_en, ex_illegal}, 32'd0);
    end
  endtask

  // One clock: check state at negedge, drive inputs, advance model at posedge
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                     input logic er, input logic fl, input logic r);
    bit   acc, pp;
    exp_t e;
    check_outputs();
    instr_valid = iv; instr = ins; rs_data = a; rt_data = b;
    ex_ready = er; flush = fl; rst = r;
    #1;
    chk("rs_addr", 32'(rs_addr), 32'(ins[25:21]));
    chk("rt_addr", 32'(rt_addr), 32'(ins[20:16]));
    acc = iv && (q.size() < 2);
    pp  = (q.size() != 0) && er;
    e   = model(ins, a, b);
    @(posedge clk);
    if (r || fl) begin
      q.delete();
      cleared = 1'b1;
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin q.push_back(e); cleared = 1'b0; end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    int rfn [14] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h27, 'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h26};
    int iop [7]  = '{'h08, 'h09, 'h0C, 'h0D, 'h0F, 'h3F, 'h23};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 1) == 0) w = rtype(w[25:21], w[20:16], ($urandom_range(0, 7) == 0) ? 0 : int'(w[15:11]),
                                             w[10:6], rfn[$urandom_range(0, 13)]);
    else w = itype(iop[$urandom_range(0, 6)], w[25:21], ($urandom_range(0, 7) == 0) ? 0 : int'(w[20:16]), w[15:0]);
    return w;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; instr_valid = 1'b0; instr = '0;
    rs_data = '0; rt_data = '0; ex_ready = 1'b0;
    cleared = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // ADD $3,$1,$2
    cyc(1'b1, rtype(1, 2, 3, 0, 'h20), 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
    chk("add_vld", 32'(ex_valid), 32'd1);
    chk("add_d1", ex_d1, 32'd5);
    chk("add_d2", ex_d2, 32'd7);
    chk("add_alu", 32'(ex_aluctrl), 32'b00010);
    chk("add_wr", {26'd0, ex_wr_en, ex_wr_reg}, {26'd0, 1'b1, 5'd3});
    idle(1);
    chk("add_gone", 32'(ex_valid), 32'd0);

    cyc(1'b1, itype('h08, 1, 4, 'hFFFF), 32'd10, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("addi_d2", ex_d2, 32'hFFFFFFFF);
    chk("addi_alu", {22'd0, ex_aluctrl, ex_wr_reg}, {22'd0, 5'b00010, 5'd4});
    idle(1);
    cyc(1'b1, itype('h0D, 1, 4, 'hFFFF), 32'd10, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("ori_d2", ex_d2, 32'h0000FFFF);
    chk("ori_alu", 32'(ex_aluctrl), 32'b00001);
    idle(1);
    cyc(1'b1, itype('h0F, 0, 4, 'h1234), 32'd99, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("lui_d2", ex_d2, 32'h12340000);
    chk("lui_alu", 32'(ex_aluctrl), 32'b00111);
    idle(1);
    cyc(1'b1, rtype(0, 6, 5, 4, 'h03), 32'd0, 32'h80000000, 1'b1, 1'b0, 1'b0);
    chk("sra_d1", ex_d1, 32'h80000000);
    chk("sra_d2", ex_d2, 32'd4);
    chk("sra_alu", 32'(ex_aluctrl), 32'b01111);
    idle(1);
    cyc(1'b1, rtype(7, 6, 5, 0, 'h06), 32'h25, 32'h1, 1'b1, 1'b0, 1'b0);
    chk("srlv_d2", ex_d2, 32'd5);
    chk("srlv_alu", 32'(ex_aluctrl), 32'b01110);
    idle(1);
    cyc(1'b1, {6'h3F, 26'h0123456}, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
    chk("ill_flag", {30'd0, ex_illegal, ex_wr_en}, 32'b10);
    chk("ill_alu", 32'(ex_aluctrl), 32'b00111);
    idle(1);
    cyc(1'b1, rtype(1, 2, 0, 0, 'h20), 32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
    chk("rd0_wren", 32'(ex_wr_en), 32'd0);
    idle(1);

    // Backpressure: three back-to-back words with ex_ready low
    cyc(1'b1, rtype(1, 2, 10, 0, 'h20), 32'd11, 32'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, rtype(1, 2, 11, 0, 'h22), 32'd22, 32'd2, 1'b0, 1'b0, 1'b0);
    chk("bp_rdy_low", 32'(instr_ready), 32'd0);
    cyc(1'b1, rtype(1, 2, 12, 0, 'h25), 32'd33, 32'd3, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_d1", ex_d1, 32'd11);
    for (int i = 0; i < 3; i++) cyc(1'b1, rtype(1, 2, 12, 0, 'h25), 32'd33, 32'd3, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Flush while FULL with a word offered
    cyc(1'b1, itype('h0D, 1, 7, 'h00AA), 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, itype('h0D, 1, 8, 'h00BB), 32'd2, 32'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, itype('h0D, 1, 9, 'h00CC), 32'd3, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("flush_vld", 32'(ex_valid), 32'd0);
    chk("flush_rdy", 32'(instr_ready), 32'd1);
    idle(3);

    // Reset mid-stream
    cyc(1'b1, itype('h0C, 2, 7, 'h0F0F), 32'd4, 32'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, itype('h0C, 2, 8, 'hF0F0), 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, itype('h0C, 2, 9, 'h1111), 32'd6, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("rst_vld", 32'(ex_valid), 32'd0);
    chk("rst_rdy", 32'(instr_ready), 32'd1);
    idle(3);

    // Random traffic
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
          $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 90) == 0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
